// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared frame geometry and grayscale type for the LED serial link
package led_pkg;

  localparam int DEF_CHANNELS   = 16;
  localparam int DEF_GS_BITS    = 12;
  localparam int DEF_FRAME_BITS = DEF_CHANNELS * DEF_GS_BITS;

  typedef logic [DEF_GS_BITS-1:0] gs_t;

endpackage

// File: rtl/led_edge_detect.sv
// rtl/led_edge_detect.sv - registered previous level plus rise pulse for a clk-sampled level
module led_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic rise
);

  logic x_q;

  always_ff @(posedge clk) begin
    if (rst) x_q <= 1'b0;
    else     x_q <= x;
  end

  assign rise = x & ~x_q;

endmodule

// File: rtl/led_gs_receiver.sv
// rtl/led_gs_receiver.sv - grayscale LED driver: serial frame shift, latch, frame check and PWM
module led_gs_receiver
  import led_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int GS_BITS  = DEF_GS_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial,
  input  logic                sclk,
  input  logic                lat,
  input  logic                gsclk,
  input  logic                blank,
  output logic [CHANNELS-1:0] out,
  output logic                sout,
  output logic                frame_ok,
  output logic                frame_err
);

  localparam int FRAME_BITS = CHANNELS * GS_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [GS_BITS-1:0] GS_MAX   = '1;

  logic                  sclk_rise, lat_rise, gsclk_rise;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] gs;
  logic [CNT_W-1:0]      bit_cnt;
  logic [GS_BITS-1:0]    gs_cnt;
  logic [CHANNELS-1:0]   lit;

  led_edge_detect u_sclk_edge  (.clk(clk), .rst(rst), .x(sclk),  .rise(sclk_rise));
  led_edge_detect u_lat_edge   (.clk(clk), .rst(rst), .x(lat),   .rise(lat_rise));
  led_edge_detect u_gsclk_edge (.clk(clk), .rst(rst), .x(gsclk), .rise(gsclk_rise));

  // gs samples the pre-shift sr, so a bit arriving with lat belongs to the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      gs        <= '0;
      bit_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (sclk_rise) sr <= {sr[FRAME_BITS-2:0], serial};
      if (lat_rise) begin
        gs      <= sr;
        bit_cnt <= sclk_rise ? CNT_W'(1) : '0;
      end else if (sclk_rise && bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      frame_ok  <= lat_rise && (bit_cnt == CNT_FULL);
      frame_err <= lat_rise && (bit_cnt != CNT_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || blank)                      gs_cnt <= '0;
    else if (gsclk_rise && gs_cnt != GS_MAX) gs_cnt <= gs_cnt + GS_BITS'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_pwm
    assign lit[i] = gs_cnt < gs[i*GS_BITS +: GS_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst || blank) out <= '0;
    else              out <= lit;
  end

  assign sout = sr[FRAME_BITS-1];

endmodule

// File: doc/led_gs_receiver.md
# led_gs_receiver

Receiving end of the LED driver serial link: a cycle-accurate RTL model of a grayscale LED driver chip that the `Controller` drives through `serial`/`sclk`/`lat`/`gsclk`. It shifts in one grayscale frame, latches it on `lat`, and produces per-channel PWM outputs counted on `gsclk`. It sits in the simulation/top-level path opposite `Controller`, one instance per `lat` bit. It provides frame-length checking and a daisy-chain output.

## Interface
- `CHANNELS`, default 16: number of PWM channels.
- `GS_BITS`, default 12: grayscale bits per channel. Frame length `FRAME_BITS` = `CHANNELS*GS_BITS` (192 by default).

- `clk`  in  1  system clock, same domain as `Controller`.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `serial`  in  1  serial data, valid when `sclk` rises.
- `sclk`  in  1  serial shift clock, a level sampled on `clk`.
- `lat`  in  1  latch strobe, a level sampled on `clk`.
- `gsclk`  in  1  grayscale count clock, a level sampled on `clk`.
- `blank`  in  1  1 = outputs off and PWM counter cleared.
- `out`  out  `CHANNELS`  PWM outputs; bit i is channel i.
- `sout`  out  1  MSB of shift register, for daisy-chaining.
- `frame_ok`  out  1  one-cycle pulse: `lat` rose after exactly `FRAME_BITS` shifts.
- `frame_err`  out  1  one-cycle pulse: `lat` rose after any other number of shifts.

## Operation
- Edge detection: each of `sclk`, `lat` and `gsclk` has a registered previous value. A rise is `x & ~x_q`. All `x_q` reset to 0.
- Shift: on an `sclk` rise, `sr <= {sr[FRAME_BITS-2:0], serial}`. Data is MSB first, so the first bit shifted ends in `sr[FRAME_BITS-1]`, which is the MSB of channel `CHANNELS-1`. Channel i occupies `sr[i*GS_BITS +: GS_BITS]`.
- `sout = sr[FRAME_BITS-1]`.
- Bit counter `bit_cnt`: increments on an `sclk` rise and saturates at `FRAME_BITS+1`, so over-length frames stay distinguishable.
- Latch: on a `lat` rise, `gs <= sr`, and `bit_cnt` restarts.
  - `frame_ok` pulses when `bit_cnt == FRAME_BITS`; otherwise `frame_err` pulses.
  - The latch always updates, even when the frame is malformed.
- PWM counter `gs_cnt` (`GS_BITS` wide):
  - `blank`=1 clears it to 0.
  - Otherwise a `gsclk` rise increments it, saturating at 2^GS_BITS-1 until the next `blank`.
- Output: `out[i] <= ~blank & (gs_cnt < gs[i])`, registered. A value of 0 never lights the channel. A value of 2^GS_BITS-1 lights it until the counter saturates.
- Reset: `sr`, `gs`, `bit_cnt`, `gs_cnt` and all `x_q` go to 0. `out`=0, `sout`=0, `frame_ok`=0, `frame_err`=0.

## Timing
- Shift: `sr` and `sout` update on the `clk` edge where the `sclk` rise is seen (the first cycle with `sclk`=1 after 0). They are visible the following cycle.
- Latch: `gs`, `frame_ok` and `frame_err` update on the same edge as the `lat` rise. The pulses are high for exactly one cycle.
- Output latency: `out` reflects a new `gs` or `gs_cnt` one cycle after that value updates. That is 2 cycles from a `gsclk` or `lat` rise.
- `blank` rising: `gs_cnt`=0 and `out`=0 on the next edge (1-cycle latency).
- Same-cycle `sclk` and `lat` rises:
  - `gs` captures the pre-shift `sr`; the new bit is not latched.
  - The new bit is shifted and counted, and `bit_cnt` becomes 1.
- Same-cycle `blank`=1 and `gsclk` rise: `blank` wins, and `gs_cnt`=0.
- `rst` wins over everything. Asserting it mid-frame discards partial shift data, and after release the frame starts fresh.
- Level inputs held high generate no further edges. A rise requires `x` to have been 0 in a previous cycle.

## Structure
- Shared package `led_pkg`: `CHANNELS`/`GS_BITS` defaults, `FRAME_BITS`, and a grayscale value typedef. `Controller` uses the same package, so both ends agree on frame length.
- One natural sub-module: `led_edge_detect` (register plus rise pulse), instantiated three times, for `sclk`, `lat` and `gsclk`.
- PWM compare is a per-channel generate loop inside the top module.

## Test plan
- Reset: `rst`=1 for 3 cycles with `sclk`/`lat`/`gsclk` toggling -> `out`=0, `sout`=0, no `frame_ok`/`frame_err`. After release, `gs_cnt`=0.
- Full frame: shift 192 bits with ch15=0xFFF, ch1=0x000, ch0=0x003, others 0x800, then pulse `lat` -> `frame_ok`=1 for one cycle, `frame_err`=0, latched values read back as written. `sout` equals the first bit 191 shifts after it entered.
- PWM: after the full frame, `blank`=0, 10 `gsclk` rises -> `out[0]` high only for counts 0..2, `out[1]` never high, `out[15]` high throughout. `blank`=1 -> `out`=0 and `gs_cnt`=0 next cycle.
- Saturation: 4100 `gsclk` rises with ch15=0xFFF -> `gs_cnt` sticks at 0xFFF and `out[15]` drops once the count reaches 0xFFF.
- Short/long frame: 100 bits then `lat` -> `frame_err` pulse and `gs` updated. 193 bits then `lat` -> `frame_err`.
- Simultaneous edges: `sclk` and `lat` rise in the same cycle after 192 bits -> `frame_ok` pulses and `gs` excludes the new bit. A following frame of 191 more bits and `lat` -> `frame_ok`.
